// File: rtl/btn_sampler.sv
// btn_sampler: turns one raw push-button pin into clean, clock-synchronous events.
//
// Chain: SYNC_STAGES-deep pin synchroniser -> counter debouncer -> press/release
// pulses -> long-press detector.
//
// Ports:
//   clk_i      user clock, all logic on the rising edge
//   rst_ni     asynchronous active-low reset
//   btn_i      raw asynchronous button pin
//   level_o    debounced state, 1 = pressed
//   press_o    one-cycle pulse when a press is accepted
//   release_o  one-cycle pulse when a release is accepted
//   long_o     one-cycle pulse once a press has lasted LONG_CNT cycles
//   held_o     high from long_o until the button is released
module btn_sampler #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CNT  = 16,
  parameter int unsigned LONG_CNT    = 128,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic held_o
);

  localparam int unsigned DcntW = $clog2(STABLE_CNT);
  localparam int unsigned HcntW = $clog2(LONG_CNT + 1);

  localparam logic [DcntW-1:0] DcntMax = DcntW'(STABLE_CNT - 1);
  localparam logic [HcntW-1:0] HcntMax = HcntW'(LONG_CNT);
  localparam logic [HcntW-1:0] HcntPre = HcntW'(LONG_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DcntW-1:0]       dcnt_q, dcnt_d;
  logic [HcntW-1:0]       hcnt_q, hcnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   long_q, long_d;
  logic                   held_q, held_d;

  logic pressed_s;  // synchronised pin, 1 = pressed
  logic rise;
  logic fall;

  assign pressed_s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], btn_i};
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    held_d    = held_q;
    rise      = 1'b0;
    fall      = 1'b0;

    // Debounce: any cycle of agreement restarts the stability count.
    if (pressed_s == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DcntMax) begin
      dcnt_d  = '0;
      level_d = pressed_s;
      rise    = pressed_s;
      fall    = ~pressed_s;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end

    // A release on the threshold edge takes priority over the long press.
    if (rise) begin
      hcnt_d  = '0;
      press_d = 1'b1;
    end else if (fall) begin
      hcnt_d    = '0;
      held_d    = 1'b0;
      release_d = 1'b1;
    end else if (level_q && (hcnt_q < HcntMax)) begin
      hcnt_d = hcnt_q + 1'b1;
      if (hcnt_q == HcntPre) begin
        long_d = 1'b1;
        held_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= {SYNC_STAGES{ACTIVE_LOW}};
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      held_q    <= held_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign held_o    = held_q;

endmodule

// File: tb/tb_btn_sampler.sv
// Testbench for btn_sampler: directed scenarios plus randomized press/release
// segments, all checked cycle by cycle against a behavioural reference model.
module tb_btn_sampler;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned STABLE_CNT  = 16;
  localparam int unsigned LONG_CNT    = 128;
  localparam bit          ACTIVE_LOW  = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = ACTIVE_LOW;
  logic level, press, release_p, long_p, held;

  always #5 clk = ~clk;

  btn_sampler #(
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CNT (STABLE_CNT),
    .LONG_CNT   (LONG_CNT),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .btn_i    (btn),
    .level_o  (level),
    .press_o  (press),
    .release_o(release_p),
    .long_o   (long_p),
    .held_o   (held)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the pin as seen after the synchroniser delay, a run
  // length of disagreeing samples, and the edge number of the last press.
  bit pipe[$];
  bit m_lvl, m_press, m_release, m_long, m_held;
  int m_run, m_press_edge, edge_no;

  // Observed-event statistics for the directed scenarios.
  int first_press, first_release, first_long, first_held;
  int n_press, n_release, n_long;

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < int'(SYNC_STAGES); i++) pipe.push_back(1'b0);
    m_lvl = 0; m_press = 0; m_release = 0; m_long = 0; m_held = 0;
    m_run = 0; m_press_edge = 0; edge_no = 0;
    first_press = -1; first_release = -1; first_long = -1; first_held = -1;
    n_press = 0; n_release = 0; n_long = 0;
  endtask

  task automatic model_edge(input bit pressed);
    bit synced;
    edge_no++;
    synced = pipe.pop_front();
    pipe.push_back(pressed);
    m_press = 0; m_release = 0;
    if (synced != m_lvl) begin
      m_run++;
      if (m_run == int'(STABLE_CNT)) begin
        m_lvl = synced;
        m_run = 0;
        if (synced) begin
          m_press = 1;
          m_press_edge = edge_no;
        end else begin
          m_release = 1;
        end
      end
    end else begin
      m_run = 0;
    end
    m_long = m_lvl && (edge_no == m_press_edge + int'(LONG_CNT));
    m_held = m_lvl && (edge_no >= m_press_edge + int'(LONG_CNT));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_level"}, 32'(level), 0);
    check_eq({tag, "_press"}, 32'(press), 0);
    check_eq({tag, "_release"}, 32'(release_p), 0);
    check_eq({tag, "_long"}, 32'(long_p), 0);
    check_eq({tag, "_held"}, 32'(held), 0);
  endtask

  // One clock cycle with the button in the given state; compare on the falling edge.
  task automatic step(input bit pressed);
    btn = ACTIVE_LOW ? ~pressed : pressed;
    @(posedge clk);
    model_edge(pressed);
    @(negedge clk);
    check_eq("level", 32'(level), 32'(m_lvl));
    check_eq("press", 32'(press), 32'(m_press));
    check_eq("release", 32'(release_p), 32'(m_release));
    check_eq("long", 32'(long_p), 32'(m_long));
    check_eq("held", 32'(held), 32'(m_held));
    if (press === 1'b1) begin
      n_press++;
      if (first_press < 0) first_press = edge_no;
    end
    if (release_p === 1'b1) begin
      n_release++;
      if (first_release < 0) first_release = edge_no;
    end
    if (long_p === 1'b1) begin
      n_long++;
      if (first_long < 0) first_long = edge_no;
    end
    if (held === 1'b1 && first_held < 0) first_held = edge_no;
  endtask

  task automatic do_reset(input bit pressed);
    btn = ACTIVE_LOW ? ~pressed : pressed;
    rst_n = 1'b0;
    #1;
    check_all_zero("in_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit cur;
    int len;
    model_reset();
    @(negedge clk);

    // Idle after reset: nothing happens.
    do_reset(1'b0);
    repeat (200) step(1'b0);
    check_eq("idle_n_press", n_press, 0);
    check_eq("idle_n_release", n_release, 0);
    check_eq("idle_n_long", n_long, 0);

    // Clean press and long hold.
    do_reset(1'b0);
    repeat (200) step(1'b1);
    check_eq("clean_press_edge", first_press, 18);
    check_eq("clean_n_press", n_press, 1);
    check_eq("clean_long_edge", first_long, 146);
    check_eq("clean_held_edge", first_held, 146);
    check_eq("clean_n_long", n_long, 1);

    // Reset while held: outputs drop without a clock edge, no release pulse.
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    check_all_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (40) step(1'b1);
    check_eq("rst_press_edge", first_press, 18);
    check_eq("rst_n_release", n_release, 0);

    // Bounce: eight 10-cycle presses separated by 2 released cycles, then hold.
    do_reset(1'b0);
    repeat (8) begin
      repeat (10) step(1'b1);
      repeat (2) step(1'b0);
    end
    repeat (40) step(1'b1);
    check_eq("bounce_press_edge", first_press, 114);
    check_eq("bounce_n_press", n_press, 1);

    // Short press.
    do_reset(1'b0);
    repeat (60) step(1'b1);
    repeat (60) step(1'b0);
    check_eq("short_press_edge", first_press, 18);
    check_eq("short_release_edge", first_release, 78);
    check_eq("short_n_long", n_long, 0);
    check_eq("short_held_seen", first_held, -1);

    // Release lands on the same edge as the long threshold: release wins.
    do_reset(1'b0);
    repeat (128) step(1'b1);
    repeat (40) step(1'b0);
    check_eq("thr_release_edge", first_release, 146);
    check_eq("thr_n_release", n_release, 1);
    check_eq("thr_n_long", n_long, 0);
    check_eq("thr_held_seen", first_held, -1);

    // One cycle later: long fires, then release clears held.
    do_reset(1'b0);
    repeat (129) step(1'b1);
    repeat (40) step(1'b0);
    check_eq("thr1_long_edge", first_long, 146);
    check_eq("thr1_release_edge", first_release, 147);
    check_eq("thr1_held_end", 32'(held), 0);

    // Randomized segments against the model.
    do_reset(1'b0);
    cur = 1'b0;
    for (int seg = 0; seg < 80; seg++) begin
      cur = ~cur;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 200))
                                        : int'($urandom_range(1, 25));
      repeat (len) step(cur);
    end
    repeat (40) step(1'b0);
    check_eq("rand_end_level", 32'(level), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
